// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the execute stage and mem_ctrl.
// The master drives requests; the slave (mem_ctrl) returns ready and responses.
interface mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_ctrl.sv
// Load/store front end for a 64K x 32 single-port RAM with sub-word read-modify-write.
// Define MEMCTRL_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses as errors.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  mem_ctrl_if.slave   bus,
  output logic        ram_rw,
  output logic [15:0] ram_address,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out
);

  typedef enum logic [1:0] {StIdle, StRead, StMerge, StWrite} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_pend_q, err_pend_d;
  logic        ram_rw_q, ram_rw_d;
  logic [15:0] ram_address_q, ram_address_d;
  logic [31:0] ram_data_in_q, ram_data_in_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;
  logic [31:0] merged;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[31:18];

`ifdef MEMCTRL_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign req_err    = (bus.req_size == 2'b11) || misaligned;
`else
  assign req_err    = (bus.req_size == 2'b11);
`endif

  // Lane selection ignores the sub-lane address bits, which forces alignment.
  always_comb begin
    byte_sel = ram_data_out[{addr_lo_q, 3'b000} +: 8];
    half_sel = ram_data_out[{addr_lo_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'b00:   load_fmt = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_fmt = ram_data_out;
    endcase
    merged = ram_data_out;
    if (size_q == 2'b00) begin
      merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    addr_lo_d     = addr_lo_q;
    wdata_d       = wdata_q;
    err_pend_d    = 1'b0;
    ram_rw_d      = 1'b0;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = 32'h0;
    rsp_err_d     = 1'b0;

    // Rejected requests answer one edge after acceptance.
    if (err_pend_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && bus.req_ready) begin
          we_d      = bus.req_we;
          size_d    = bus.req_size;
          uns_d     = bus.req_unsigned;
          addr_lo_d = bus.req_addr[1:0];
          wdata_d   = bus.req_wdata[15:0];
          if (req_err) begin
            err_pend_d = 1'b1;
          end else if (bus.req_we && (bus.req_size == 2'b10)) begin
            ram_rw_d      = 1'b1;
            ram_address_d = bus.req_addr[17:2];
            ram_data_in_d = bus.req_wdata;
            state_d       = StWrite;
          end else begin
            ram_address_d = bus.req_addr[17:2];
            state_d       = StRead;
          end
        end
      end
      StRead: state_d = StMerge;
      StMerge: begin
        if (!we_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_fmt;
          state_d     = StIdle;
        end else begin
          ram_rw_d      = 1'b1;
          ram_data_in_d = merged;
          state_d       = StWrite;
        end
      end
      StWrite: begin
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      addr_lo_q     <= 2'b00;
      wdata_q       <= 16'h0;
      err_pend_q    <= 1'b0;
      ram_rw_q      <= 1'b0;
      ram_address_q <= 16'h0;
      ram_data_in_q <= 32'h0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      addr_lo_q     <= addr_lo_d;
      wdata_q       <= wdata_d;
      err_pend_q    <= err_pend_d;
      ram_rw_q      <= ram_rw_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle) && !rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign ram_rw        = ram_rw_q;
  assign ram_address   = ram_address_q;
  assign ram_data_in   = ram_data_in_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a behavioural 64K x 32 RAM and a response scoreboard.
// Expectations for misaligned accesses follow MEMCTRL_MISALIGN_TRAP_EN.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        ram_rw;
  logic [15:0] ram_address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;

  always #5 clk = ~clk;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ram_rw       (ram_rw),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  logic [31:0] mem [0:65535];
  int          wr_count = 0;
  logic [15:0] last_wr_addr = 16'h0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rw) begin
      mem[ram_address] <= ram_data_in;
      wr_count         <= wr_count + 1;
      last_wr_addr     <= ram_address;
    end
    ram_data_out <= mem[ram_address];
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } txn_t;

  txn_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Drives one request from posedge+1 and waits (bounded) for its response pulse.
  task automatic do_req(input txn_t t, output logic [31:0] rdata, output logic err,
                        output int lat, output int acc_cyc);
    bus.req_valid    = 1'b1;
    bus.req_we       = t.we;
    bus.req_size     = t.size;
    bus.req_unsigned = t.uns;
    bus.req_addr     = t.addr;
    bus.req_wdata    = t.wdata;
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    bus.req_valid    = 1'b0;
    bus.req_we       = $urandom_range(1, 0) == 1;
    bus.req_size     = 2'($urandom_range(3, 0));
    bus.req_unsigned = $urandom_range(1, 0) == 1;
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    lat   = -1;
    rdata = 32'hx;
    err   = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        lat   = i;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset req_ready: got %b want 0", bus.req_ready);
    end
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_err, ram_rw} !== 3'b000) begin
      n_fail++; $display("FAIL reset flags: got %b want 000", {bus.rsp_valid, bus.rsp_err, ram_rw});
    end
    n_checks++;
    if (bus.rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset rsp_rdata: got %h want 0", bus.rsp_rdata);
    end
    n_checks++;
    if ({ram_address, ram_data_in} !== 48'h0) begin
      n_fail++; $display("FAIL reset ram bus: got %h/%h want 0/0", ram_address, ram_data_in);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset release req_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_word();
    txn_t        tab[2];
    txn_t        exp;
    logic [31:0] r;
    logic        e;
    int          l, a, w0;
    tab[0] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1};
    tab[1] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2};
    w0 = wr_count;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(tab[i]);
      do_req(tab[i], r, e, l, a);
      exp = sb.pop_front();
      n_checks++;
      if (r !== exp.rdata || e !== exp.err) begin
        n_fail++; $display("FAIL word[%0d] rsp: got %h/%b want %h/%b", i, r, e, exp.rdata, exp.err);
      end
      n_checks++;
      if (l !== exp.lat) begin
        n_fail++; $display("FAIL word[%0d] latency: got %0d want %0d", i, l, exp.lat);
      end
      n_checks++;
      if (bus.req_ready !== 1'b1 || ram_rw !== 1'b0) begin
        n_fail++; $display("FAIL word[%0d] ready/rw at rsp: got %b/%b want 1/0", i, bus.req_ready, ram_rw);
      end
    end
    n_checks++;
    if (wr_count - w0 !== 1 || last_wr_addr !== 16'h0004) begin
      n_fail++; $display("FAIL word ram writes: got %0d at %h want 1 at 0004", wr_count - w0, last_wr_addr);
    end
  endtask

  task automatic test_subword();
    txn_t        tab[11];
    txn_t        exp;
    logic [31:0] r;
    logic        e;
    int          l, a;
    tab[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 1};
    tab[1]  = '{1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFAA, 32'h0, 1'b0, 3};
    tab[2]  = '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2};
    tab[3]  = '{1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2};
    tab[4]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1122AA44, 1'b0, 2};
    tab[5]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h12348001, 32'h0, 1'b0, 3};
    tab[6]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2};
    tab[7]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00008001, 1'b0, 2};
    tab[8]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2};
    tab[9]  = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h00000044, 1'b0, 2};
    tab[10] = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFAA44, 1'b0, 2};
    for (int i = 0; i < 11; i++) begin
      sb.push_back(tab[i]);
      do_req(tab[i], r, e, l, a);
      exp = sb.pop_front();
      n_checks++;
      if (r !== exp.rdata || e !== exp.err || l !== exp.lat) begin
        n_fail++;
        $display("FAIL subword[%0d]: got %h/%b/%0d want %h/%b/%0d", i, r, e, l, exp.rdata, exp.err, exp.lat);
      end
    end
    n_checks++;
    if (mem[4] !== 32'h8001AA44) begin
      n_fail++; $display("FAIL subword ram[4]: got %h want 8001aa44", mem[4]);
    end
  endtask

  task automatic test_misalign();
    txn_t        tab[3];
    txn_t        exp;
    logic [31:0] r;
    logic        e;
    logic [31:0] exp_mem;
    int          l, a, w0, exp_w;
`ifdef MEMCTRL_MISALIGN_TRAP_EN
    tab[0] = '{1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1};
    tab[1] = '{1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1};
    tab[2] = '{1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 32'h0, 1'b1, 1};
    exp_mem = 32'h8001AA44;
    exp_w   = 0;
`else
    tab[0] = '{1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'hFFFF8001, 1'b0, 2};
    tab[1] = '{1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h8001AA44, 1'b0, 2};
    tab[2] = '{1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 32'h0, 1'b0, 3};
    exp_mem = 32'h80015555;
    exp_w   = 1;
`endif
    w0 = wr_count;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(tab[i]);
      do_req(tab[i], r, e, l, a);
      exp = sb.pop_front();
      n_checks++;
      if (r !== exp.rdata || e !== exp.err || l !== exp.lat) begin
        n_fail++;
        $display("FAIL misalign[%0d]: got %h/%b/%0d want %h/%b/%0d", i, r, e, l, exp.rdata, exp.err, exp.lat);
      end
    end
    n_checks++;
    if (mem[4] !== exp_mem || wr_count - w0 !== exp_w) begin
      n_fail++;
      $display("FAIL misalign ram: got %h (%0d writes) want %h (%0d)", mem[4], wr_count - w0, exp_mem, exp_w);
    end
  endtask

  task automatic test_errors();
    txn_t        tab[2];
    txn_t        exp;
    logic [31:0] r, m0;
    logic        e;
    int          l, a, w0;
    tab[0] = '{1'b1, 2'b11, 1'b0, 32'h10, 32'h0BADF00D, 32'h0, 1'b1, 1};
    tab[1] = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1};
    w0 = wr_count;
    m0 = mem[4];
    for (int i = 0; i < 2; i++) begin
      sb.push_back(tab[i]);
      do_req(tab[i], r, e, l, a);
      exp = sb.pop_front();
      n_checks++;
      if (r !== exp.rdata || e !== exp.err || l !== exp.lat) begin
        n_fail++;
        $display("FAIL error[%0d]: got %h/%b/%0d want %h/%b/%0d", i, r, e, l, exp.rdata, exp.err, exp.lat);
      end
    end
    n_checks++;
    if (wr_count !== w0 || mem[4] !== m0) begin
      n_fail++; $display("FAIL error ram touched: got %0d writes, %h want 0, %h", wr_count - w0, mem[4], m0);
    end
  endtask

  task automatic test_wrap();
    txn_t        tab[2];
    txn_t        exp;
    logic [31:0] r;
    logic        e;
    int          l, a;
    tab[0] = '{1'b1, 2'b10, 1'b0, 32'h0004_0010, 32'hCAFEF00D, 32'h0, 1'b0, 1};
    tab[1] = '{1'b0, 2'b10, 1'b0, 32'hFFFC_0010, 32'h0, 32'hCAFEF00D, 1'b0, 2};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(tab[i]);
      do_req(tab[i], r, e, l, a);
      exp = sb.pop_front();
      n_checks++;
      if (r !== exp.rdata || e !== exp.err || l !== exp.lat) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h/%b/%0d want %h/%b/%0d", i, r, e, l, exp.rdata, exp.err, exp.lat);
      end
    end
    n_checks++;
    if (mem[4] !== 32'hCAFEF00D || last_wr_addr !== 16'h0004) begin
      n_fail++; $display("FAIL wrap ram: got %h at %h want cafef00d at 0004", mem[4], last_wr_addr);
    end
  endtask

  task automatic test_back_to_back();
    txn_t        tab[4];
    txn_t        exp;
    logic [31:0] r;
    logic        e;
    int          l;
    int          acc[4];
    tab[0] = '{1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5_0001, 32'h0, 1'b0, 1};
    tab[1] = '{1'b1, 2'b10, 1'b0, 32'h24, 32'h5A5A_0002, 32'h0, 1'b0, 1};
    tab[2] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hA5A5_0001, 1'b0, 2};
    tab[3] = '{1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h5A5A_0002, 1'b0, 2};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(tab[i]);
      do_req(tab[i], r, e, l, acc[i]);
      exp = sb.pop_front();
      n_checks++;
      if (r !== exp.rdata || e !== exp.err || l !== exp.lat) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %h/%b/%0d want %h/%b/%0d", i, r, e, l, exp.rdata, exp.err, exp.lat);
      end
    end
    n_checks++;
    if (acc[1] - acc[0] !== 2) begin
      n_fail++; $display("FAIL b2b store spacing: got %0d want 2", acc[1] - acc[0]);
    end
    n_checks++;
    if (acc[3] - acc[2] !== 3) begin
      n_fail++; $display("FAIL b2b load spacing: got %0d want 3", acc[3] - acc[2]);
    end
  endtask

  task automatic test_reset_mid();
    txn_t        t;
    logic [31:0] r;
    logic        e;
    int          l, a, w0;
    logic        saw_rsp;
    t = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 1};
    do_req(t, r, e, l, a);
    w0 = wr_count;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h11;
    bus.req_wdata    = 32'hAA;
    @(posedge clk);  // accept, READ follows
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);  // now in MERGE
    #1;
    rst = 1'b1;
    saw_rsp = 1'b0;
    @(posedge clk);
    #1;
    saw_rsp |= bus.rsp_valid;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset req_ready during rst: got %b want 0", bus.req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset req_ready after rst: got %b want 1", bus.req_ready);
    end
    repeat (4) begin
      saw_rsp |= bus.rsp_valid;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (saw_rsp !== 1'b0) begin
      n_fail++; $display("FAIL midreset rsp_valid: got %b want 0", saw_rsp);
    end
    n_checks++;
    if (wr_count !== w0 || mem[4] !== 32'h11223344) begin
      n_fail++; $display("FAIL midreset ram: got %0d writes, %h want 0, 11223344", wr_count - w0, mem[4]);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_misalign();
    test_errors();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Load/store front end placed directly upstream of the 64K x 32 word RAM. Accepts byte, halfword and word requests from the execute stage over a valid/ready handshake. Drives the RAM's single rw/address/data port and performs read-modify-write for sub-word stores. Returns formatted (sign- or zero-extended) load data as a one-cycle response pulse.

## Interface
- No parameters; widths fixed to the RAM: 16-bit word address, 32-bit data.
- clk  in  1  rising-edge clock shared with the RAM
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE and not in reset
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address; word index = req_addr[17:2], bits [31:18] ignored (wrap modulo 256 KiB)
- req_wdata  in  32  store data, right-aligned for byte/halfword
- rsp_valid  out  1  one-cycle completion pulse (loads and stores)
- rsp_rdata  out  32  formatted load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid; request rejected, no RAM write
- ram_rw  out  1  to RAM rw (0 read, 1 write)
- ram_address  out  16  to RAM address
- ram_data_in  out  32  to RAM data_in
- ram_data_out  in  32  from RAM data_out, valid the cycle after the RAM samples a read

## Operation
- Little-endian: byte lane k = bits [8k+7:8k]; halfword lane = addr[1].
- FSM states: IDLE, READ, MERGE, WRITE.
- IDLE: req_ready=1. Accept on req_valid & req_ready; latch all req_* fields.
  - Error (size 11, or misaligned when trapping enabled): stay IDLE, pulse rsp_valid+rsp_err, no RAM access.
  - Word store: -> WRITE with ram_rw=1, ram_address=index, ram_data_in=req_wdata.
  - Load or sub-word store: -> READ with ram_rw=0, ram_address=index.
- READ: RAM samples read this edge -> MERGE.
- MERGE: ram_data_out valid.
  - Load: select lane, extend per req_unsigned, pulse rsp_valid, -> IDLE.
  - Sub-word store: replace selected lane(s) with low bits of req_wdata, keep other lanes; ram_rw=1, ram_data_in=merged -> WRITE.
- WRITE: RAM writes this edge; ram_rw returns to 0; pulse rsp_valid (rsp_rdata=0) -> IDLE.
- ram_rw, ram_address, ram_data_in, rsp_* are registered. ram_rw is 1 for exactly one cycle per store; ram_address/ram_data_in hold last value otherwise.
- No response backpressure; requester must take rsp_valid when pulsed.

## Timing
- Reset values: state IDLE, req_ready 0 while rst high, rsp_valid 0, rsp_rdata 0, rsp_err 0, ram_rw 0, ram_address 0, ram_data_in 0.
- Accept edge = E0. rsp_valid visible after: error E1; word store E1; load E2; sub-word store E3.
- req_ready returns high in the cycle rsp_valid is high, so back-to-back word stores sustain 1 per 2 cycles and loads 1 per 3.
- Reset mid-operation: FSM aborts to IDLE and no response is issued. A write whose ram_rw=1 is already presented at the reset edge commits, because the RAM has no reset. No other write occurs.
- Signals are sampled only at rising edges; req_* values are don't-care outside acceptance.

## Configuration
- MEMCTRL_MISALIGN_TRAP_EN defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, completes as an error at E1.
  - No RAM access; rsp_rdata=0.
- Undefined:
  - Misaligned low bits are forced to alignment (halfword ignores addr[0]; word ignores addr[1:0]) and the access proceeds normally.
  - rsp_err is raised only for size 11.

## Test plan
- Word store 0xDEADBEEF at 0x0000_0010, then word load at 0x10 -> ram_rw=1 for one cycle at address 0x0004; load rsp_rdata=0xDEADBEEF two cycles after accept.
- Word RAM[4]=0x11223344; byte store 0xAA at 0x11 -> RAM[4]=0x1122AA44. Signed byte load at 0x11 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Halfword store 0x8001 at 0x12 onto 0x1122AA44 -> 0x8001AA44. Signed halfword load at 0x12 -> 0xFFFF8001.
- Halfword load at 0x13 with MEMCTRL_MISALIGN_TRAP_EN -> rsp_err=1 at E1, no RAM write. Without the macro -> same data as load at 0x12, rsp_err=0.
- req_size=11 store -> rsp_err=1 at E1, RAM unchanged. Address 0x0004_0010 word store -> lands at RAM[4] (wrap).
- Assert rst during MERGE of a byte store -> no rsp_valid, RAM word unchanged, req_ready=0 during reset and 1 the cycle after rst deasserts.
